// File: rtl/cute_lock_key_sequencer.sv
// rtl/cute_lock_key_sequencer.sv - key schedule driver for a counter-phased locked FSM
// Loads a key table in IDLE, then replays it slot by slot in phase with the lock's counter.
module cute_lock_key_sequencer #(
    parameter int KEY_W     = 3,
    parameter int NUM_KEYS  = 2,
    parameter int PHASE_LEN = 2,
    parameter int PERIOD    = NUM_KEYS * PHASE_LEN,
    parameter int PHASE_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1,
    parameter int IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [IDX_W-1:0]   load_idx,
    input  logic [KEY_W-1:0]   load_key,
    input  logic               arm,
    input  logic               stop,
    output logic [KEY_W-1:0]   keyinput,
    output logic [PHASE_W-1:0] phase,
    output logic               running,
    output logic               loaded,
    output logic               err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PERIOD - 1);

    state_t                state;
    logic [KEY_W-1:0]      key_table [NUM_KEYS];
    logic [NUM_KEYS-1:0]   mask;
    logic [PHASE_W-1:0]    next_phase;
    logic [IDX_W-1:0]      next_slot;
    logic                  load_hit;

    assign load_ready = (state == IDLE);
    assign loaded     = &mask;
    assign load_hit   = (state == IDLE) && load_valid && (int'(load_idx) < NUM_KEYS);

    // Slot index is derived from the phase the counter is about to take, so the
    // registered key lines up with the lock's counter with zero latency.
    always_comb begin
        int slot_int;
        next_phase = (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        slot_int   = int'(next_phase) / PHASE_LEN;
        if (slot_int >= NUM_KEYS) begin
            slot_int = NUM_KEYS - 1;
        end
        next_slot  = IDX_W'(slot_int);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mask     <= '0;
            keyinput <= '0;
            phase    <= '0;
            running  <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_table[i] <= '0;
            end
        end else begin
            if (load_hit) begin
                key_table[load_idx] <= load_key;
                mask[load_idx]      <= 1'b1;
            end
            case (state)
                IDLE: begin
                    keyinput <= '0;
                    phase    <= '0;
                    running  <= 1'b0;
                    // Arm sees the mask from before this edge; a same-cycle write does not count.
                    if (arm) begin
                        if (&mask) begin
                            state    <= RUN;
                            running  <= 1'b1;
                            keyinput <= key_table[0];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state    <= IDLE;
                        running  <= 1'b0;
                        phase    <= '0;
                        keyinput <= '0;
                    end else begin
                        phase    <= next_phase;
                        keyinput <= key_table[next_slot];
                    end
                end
                default: begin
                    state    <= IDLE;
                    running  <= 1'b0;
                    phase    <= '0;
                    keyinput <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cute_lock_key_sequencer.sv
// tb/tb_cute_lock_key_sequencer.sv - directed self-checking bench for cute_lock_key_sequencer
module tb_cute_lock_key_sequencer;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [0:0] load_idx;
    logic [2:0] load_key;
    logic       arm;
    logic       stop;
    logic [2:0] keyinput;
    logic [1:0] phase;
    logic       running;
    logic       loaded;
    logic       err;

    int checks;
    int failures;

    cute_lock_key_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_key   (load_key),
        .arm        (arm),
        .stop       (stop),
        .keyinput   (keyinput),
        .phase      (phase),
        .running    (running),
        .loaded     (loaded),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_err);
        chk({tag, "_running"},  32'(running),  32'd0);
        chk({tag, "_keyinput"}, 32'(keyinput), 32'd0);
        chk({tag, "_phase"},    32'(phase),    32'd0);
        chk({tag, "_err"},      32'(err),      32'(exp_err));
    endtask

    logic [2:0] exp_key [5];
    logic [1:0] exp_ph  [5];

    initial begin
        checks = 0;
        failures = 0;
        exp_key[0] = 3'b010; exp_key[1] = 3'b010; exp_key[2] = 3'b101;
        exp_key[3] = 3'b101; exp_key[4] = 3'b010;
        exp_ph[0] = 2'd0; exp_ph[1] = 2'd1; exp_ph[2] = 2'd2; exp_ph[3] = 2'd3; exp_ph[4] = 2'd0;

        rst = 1'b1; load_valid = 1'b0; load_idx = 1'b0; load_key = 3'b000;
        arm = 1'b0; stop = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset", 1'b0);
        chk("reset_loaded", 32'(loaded), 32'd0);
        chk("reset_load_ready", 32'(load_ready), 32'd1);

        // Only slot0 loaded: arm must be rejected.
        load_valid = 1'b1; load_idx = 1'b0; load_key = 3'b010;
        tick();
        load_valid = 1'b0;
        chk("partial_loaded", 32'(loaded), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk_idle("arm_unloaded", 1'b1);
        chk("arm_unloaded_loaded", 32'(loaded), 32'd0);

        // Last slot written in the same cycle as arm: arm still rejected.
        load_valid = 1'b1; load_idx = 1'b1; load_key = 3'b101; arm = 1'b1;
        tick();
        load_valid = 1'b0; arm = 1'b0;
        chk_idle("arm_same_cycle", 1'b1);
        chk("arm_same_cycle_loaded", 32'(loaded), 32'd1);

        // Stop alone in IDLE does nothing.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_running", 32'(running), 32'd0);

        // Arm and stop together in IDLE: arm wins; then the schedule plays.
        arm = 1'b1; stop = 1'b1;
        tick();
        arm = 1'b0; stop = 1'b0;
        chk("run_load_ready", 32'(load_ready), 32'd0);
        chk("run_running", 32'(running), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk($sformatf("sched%0d_key", i),   32'(keyinput), 32'(exp_key[i]));
            chk($sformatf("sched%0d_phase", i), 32'(phase),    32'(exp_ph[i]));
        end

        // Loads in RUN are refused; arm in RUN is ignored.
        load_valid = 1'b1; load_idx = 1'b0; load_key = 3'b111; arm = 1'b1;
        chk("run_load_refused", 32'(load_ready), 32'd0);
        tick();
        chk("run_arm_ignored_phase", 32'(phase), 32'd1);
        chk("run_arm_ignored_key", 32'(keyinput), 32'b010);
        arm = 1'b0;
        tick();
        load_valid = 1'b0;
        chk("run_p2_phase", 32'(phase), 32'd2);
        chk("run_p2_key", 32'(keyinput), 32'b101);

        // Stop at phase 2.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("stop", 1'b1);
        chk("stop_load_ready", 32'(load_ready), 32'd1);

        // Re-arm restarts at phase 0 with the original slot0 key.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_running", 32'(running), 32'd1);
        chk("rearm_phase", 32'(phase), 32'd0);
        chk("rearm_key", 32'(keyinput), 32'b010);
        tick();
        tick();
        tick();
        chk("rearm_p3_phase", 32'(phase), 32'd3);
        chk("rearm_p3_key", 32'(keyinput), 32'b101);

        // Reset mid-RUN clears everything, including the load mask.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midrun_reset", 1'b0);
        chk("midrun_reset_loaded", 32'(loaded), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk_idle("post_reset_arm", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
